// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the 32-bit instruction base-field marker and the PC increment.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // nothing outstanding
    ST_REQ  = 2'd1,  // imem_req high, awaiting ack
    ST_WAIT = 2'd2,  // ack seen, awaiting rvalid
    ST_DROP = 2'd3   // awaiting rvalid whose data is discarded
  } fetch_state_e;

  localparam logic [1:0]  INSTR_BASE_32 = 2'b11;
  localparam int unsigned PC_STEP       = 4;

endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: small synchronous FIFO holding fetched {instr, pc} entries.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push_i/data_i   write an entry (accepted when full only if popping too)
//   pop_i           drop the head entry (ignored when empty)
//   flush_i         empty the FIFO; wins over push and pop
//   head_o          head entry, read straight from the storage registers
//   full_o/empty_o  occupancy flags
//   count_o         number of valid entries
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetcher feeding a decode stage
// through a small buffer (fetch_fifo).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   imem_req/imem_addr            fetch request and word-aligned address
//   imem_ack                      memory accepted the request
//   imem_rvalid/imem_rdata        read response (at least one cycle after ack)
//   redirect/redirect_pc          flush and restart fetch at redirect_pc
//   out_valid/out_ready           handshake to decode
//   out_instr/out_pc/out_illegal  buffered instruction, its PC, base-field flag
// Build option: define FETCH_ILLEGAL_CHECK_EN to store and present the
// per-entry illegal flag; otherwise out_illegal is tied low.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned           ADDR_SIZE  = 32,
  parameter int unsigned           WORD_SIZE  = 32,
  parameter logic [ADDR_SIZE-1:0]  RESET_PC   = ADDR_SIZE'(32'h0000_0000),
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [ADDR_SIZE-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic                 imem_rvalid,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  input  logic                 redirect,
  input  logic [ADDR_SIZE-1:0] redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_instr,
  output logic [ADDR_SIZE-1:0] out_pc,
  output logic                 out_illegal
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef FETCH_ILLEGAL_CHECK_EN
  localparam int unsigned ENTRY_W = WORD_SIZE + ADDR_SIZE + 1;
`else
  localparam int unsigned ENTRY_W = WORD_SIZE + ADDR_SIZE;
`endif
  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK  = ~ADDR_SIZE'(3);
  localparam logic [ADDR_SIZE-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

  fetch_state_e         state_q, state_d;
  logic [ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_SIZE-1:0] inflight_pc_q, inflight_pc_d;
  logic                 imem_req_q;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [ENTRY_W-1:0]   fifo_wdata;
  logic [ENTRY_W-1:0]   fifo_head;
  logic                 slot_left;

  assign fifo_pop  = out_ready && !fifo_empty;
  assign out_valid = !fifo_empty;
  assign imem_req  = imem_req_q;
  assign imem_addr = fetch_pc_q;

  // In WAIT the FIFO holds at most DEPTH-1 entries (the reserved slot), so
  // after this push a slot is still free unless that was the last one.
  assign slot_left = fifo_pop || (fifo_count < CNT_W'(FIFO_DEPTH - 1));

`ifdef FETCH_ILLEGAL_CHECK_EN
  assign fifo_wdata = {(imem_rdata[1:0] != INSTR_BASE_32), imem_rdata, inflight_pc_q};
  assign {out_illegal, out_instr, out_pc} = fifo_head;
`else
  assign fifo_wdata = {imem_rdata, inflight_pc_q};
  assign {out_instr, out_pc} = fifo_head;
  assign out_illegal = 1'b0;
`endif

  // Next-state logic; redirect overrides pushes, acks and the fetch PC.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    fifo_push     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect || !fifo_full) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ack) begin
          fetch_pc_d    = fetch_pc_q + ADDR_SIZE'(PC_STEP);
          inflight_pc_d = fetch_pc_q;
          state_d       = redirect ? ST_DROP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response arriving with the redirect is consumed and discarded.
        if (redirect) begin
          state_d = imem_rvalid ? ST_REQ : ST_DROP;
        end else if (imem_rvalid) begin
          fifo_push = 1'b1;
          state_d   = slot_left ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirect) fetch_pc_d = redirect_pc & ALIGN_MASK;
  end

  // State and address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= RESET_PC_AL;
      inflight_pc_q <= RESET_PC_AL;
      imem_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      imem_req_q    <= (state_d == ST_REQ);
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule
